rob_mc: RTL and testbench

- Parametrised successor reorder buffer for the Tomasulo RV32I core.
- Accepts one issue per cycle and takes N_CDB concurrent writeback broadcasts.
- Retires up to COMMIT_W ready entries per cycle, in order.
- Supports partial flush, which discards all entries younger than a given ROB index (branch mispredict recovery). Sits between dispatch, the reservation stations/CDB arbiter, the register file and the load/store unit.

---
 rtl/rv32i_types.sv | 37 +++
 rtl/rob_commit_sel.sv | 37 +++
 rtl/rob_mc.sv | 168 ++++++++++++++++
 tb/tb_rob_mc.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: ROB entry, CDB broadcast, opcode constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv32i_types;

    localparam logic [6:0] op_store = 7'b0100011;

    // Tag width on the CDB; wide enough for any ROB up to 64 entries.
    localparam int ROB_TAG_W = 6;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic        ready;
    } rob_entry_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_entry;
        logic [31:0]          rd_data;
        logic [31:0]          rs1_data;
        logic [31:0]          rs2_data;
        logic [31:0]          mem_addr;
        logic [3:0]           mem_rmask;
        logic [3:0]           mem_wmask;
        logic [31:0]          mem_rdata;
        logic [31:0]          mem_wdata;
    } cdb_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Picks how many head entries retire this cycle (in-order, stores only in slot 0).
// Latency: combinational.
// Backpressure: commit_hold or flush forces zero commits.
module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int CNTW     = 5,
    parameter int NW       = 2
) (
    input  logic [COMMIT_W-1:0] slot_ready,
    input  logic [COMMIT_W-1:0] slot_store,
    input  logic [CNTW-1:0]     count,
    input  logic                commit_hold,
    input  logic                flush,
    output logic [NW-1:0]       n,
    output logic [COMMIT_W-1:0] slot_valid
);

    logic stop;

    // Walk the candidate slots oldest first; the first non-committing slot ends the group.
    always_comb begin
        n          = '0;
        slot_valid = '0;
        stop       = commit_hold | flush;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (!stop && (CNTW'(k) < count) && slot_ready[k] && (k == 0 || !slot_store[k])) begin
                slot_valid[k] = 1'b1;
                n             = NW'(k + 1);
                // A store retires alone so the memory side sees one store per cycle.
                if (slot_store[k]) stop = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_mc.sv
// Reorder buffer: in-order issue, N_CDB writeback ports, up to COMMIT_W in-order retires, partial flush.
// Latency: CDB write -> ready after 1 edge; commit_valid registered one edge after ready is seen.
// Backpressure: issue_ready = !full from registered count; commit_hold stalls all retirement.
module rob_mc
    import rv32i_types::*;
#(
    parameter  int DEPTH    = 16,
    parameter  int N_CDB    = 2,
    parameter  int COMMIT_W = 2,
    localparam int IDXW     = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue,
    input  rob_entry_t                        issue_entry,
    output logic                              issue_ready,
    output logic [IDXW-1:0]                   issue_idx,
    input  cdb_t [N_CDB-1:0]                  cdb,
    input  logic [N_CDB-1:0]                  cdb_en,
    input  logic                              commit_hold,
    input  logic                              flush,
    input  logic [IDXW-1:0]                   flush_idx,
    output logic [COMMIT_W-1:0]               commit_valid,
    output rob_entry_t [COMMIT_W-1:0]         commit_entry,
    output logic [COMMIT_W-1:0][IDXW-1:0]     commit_idx,
    output rob_entry_t [DEPTH-1:0]            rob_data,
    output logic [IDXW:0]                     count,
    output logic                              full,
    output logic                              empty
);

    localparam int CNTW = IDXW + 1;
    localparam int NW   = $clog2(COMMIT_W + 1);
    localparam int TAGX = ROB_TAG_W + 1;

    typedef logic [IDXW-1:0] rob_idx_t;
    typedef logic [CNTW-1:0] rob_ptr_t;

    rob_ptr_t                  head;
    rob_ptr_t                  tail;
    rob_idx_t                  head_idx;
    rob_entry_t [DEPTH-1:0]    arr;
    rob_entry_t [DEPTH-1:0]    arr_nxt;
    rob_ptr_t                  flush_off;
    logic                      issue_acc;
    rob_idx_t                  ci;
    logic                      cdb_hit;

    rob_entry_t [COMMIT_W-1:0] slot_entry;
    rob_idx_t   [COMMIT_W-1:0] slot_idx;
    logic       [COMMIT_W-1:0] slot_ready;
    logic       [COMMIT_W-1:0] slot_store;
    logic       [COMMIT_W-1:0] slot_valid;
    logic       [NW-1:0]       n;

    // Age of index i relative to the head (0 = oldest), modulo DEPTH.
    function automatic rob_ptr_t age(input rob_idx_t i, input rob_idx_t h);
        rob_idx_t d;
        d = i - h;
        return {1'b0, d};
    endfunction

    assign head_idx    = head[IDXW-1:0];
    assign count       = tail - head;
    assign full        = (count == rob_ptr_t'(DEPTH));
    assign empty       = (count == '0);
    assign issue_ready = !full;
    assign issue_idx   = tail[IDXW-1:0];
    assign rob_data    = arr;
    assign flush_off   = age(flush_idx, head_idx);
    assign issue_acc   = issue && !full && !flush;

    // Gather the commit candidates starting at the head, wrapping modulo DEPTH.
    always_comb begin
        slot_entry = '0;
        slot_idx   = '0;
        slot_ready = '0;
        slot_store = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k]   = head_idx + rob_idx_t'(k);
            slot_entry[k] = arr[slot_idx[k]];
            slot_ready[k] = slot_entry[k].ready;
            slot_store[k] = (slot_entry[k].inst[6:0] == op_store);
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .CNTW     (CNTW),
        .NW       (NW)
    ) u_sel (
        .slot_ready  (slot_ready),
        .slot_store  (slot_store),
        .count       (count),
        .commit_hold (commit_hold),
        .flush       (flush),
        .n           (n),
        .slot_valid  (slot_valid)
    );

    // Next array state: CDB writebacks, commit ready-clear, issue allocation, flush squash.
    always_comb begin
        arr_nxt = arr;
        ci      = '0;
        cdb_hit = 1'b0;
        // Ascending port order so the highest port wins on a shared index.
        for (int p = 0; p < N_CDB; p++) begin
            ci      = cdb[p].rob_entry[IDXW-1:0];
            cdb_hit = cdb_en[p]
                      && (TAGX'(cdb[p].rob_entry) < TAGX'(DEPTH))
                      && (age(ci, head_idx) < count)
                      && (!flush || age(ci, head_idx) <= flush_off);
            if (cdb_hit) begin
                arr_nxt[ci].rd_data   = cdb[p].rd_data;
                arr_nxt[ci].rs1_data  = cdb[p].rs1_data;
                arr_nxt[ci].rs2_data  = cdb[p].rs2_data;
                arr_nxt[ci].mem_addr  = cdb[p].mem_addr;
                arr_nxt[ci].mem_rmask = cdb[p].mem_rmask;
                arr_nxt[ci].mem_wmask = cdb[p].mem_wmask;
                arr_nxt[ci].mem_rdata = cdb[p].mem_rdata;
                arr_nxt[ci].mem_wdata = cdb[p].mem_wdata;
                arr_nxt[ci].ready     = 1'b1;
            end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            if (slot_valid[k]) arr_nxt[slot_idx[k]].ready = 1'b0;
        end
        if (issue_acc) begin
            arr_nxt[issue_idx]       = issue_entry;
            arr_nxt[issue_idx].ready = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((age(rob_idx_t'(i), head_idx) < count) && (age(rob_idx_t'(i), head_idx) > flush_off))
                    arr_nxt[i].ready = 1'b0;
            end
        end
    end

    // Pointer, array and registered commit-port state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            arr          <= '0;
            commit_valid <= '0;
            commit_entry <= '0;
            commit_idx   <= '0;
        end else begin
            arr          <= arr_nxt;
            commit_valid <= slot_valid;
            for (int k = 0; k < COMMIT_W; k++) begin
                if (slot_valid[k]) begin
                    commit_entry[k] <= slot_entry[k];
                    commit_idx[k]   <= slot_idx[k];
                end
            end
            if (flush) begin
                // flush_idx survives; everything younger is dropped from the tail.
                tail <= head + flush_off + rob_ptr_t'(1);
            end else begin
                head <= head + rob_ptr_t'(n);
                if (issue_acc) tail <= tail + rob_ptr_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_rob_mc.sv
// Randomized + directed bench for rob_mc against a queue-based reference model.
// Latency: model predicts post-edge outputs, sampled 1 time unit after each rising edge.
// Backpressure: exercises full-drop, commit_hold and flush squashing.
module tb_rob_mc;
    import rv32i_types::*;

    localparam int DEPTH    = 16;
    localparam int N_CDB    = 2;
    localparam int COMMIT_W = 2;
    localparam int IDXW     = 4;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          issue;
    rob_entry_t                    issue_entry;
    logic                          issue_ready;
    logic [IDXW-1:0]               issue_idx;
    cdb_t [N_CDB-1:0]              cdb;
    logic [N_CDB-1:0]              cdb_en;
    logic                          commit_hold;
    logic                          flush;
    logic [IDXW-1:0]               flush_idx;
    logic [COMMIT_W-1:0]           commit_valid;
    rob_entry_t [COMMIT_W-1:0]     commit_entry;
    logic [COMMIT_W-1:0][IDXW-1:0] commit_idx;
    rob_entry_t [DEPTH-1:0]        rob_data;
    logic [IDXW:0]                 count;
    logic                          full;
    logic                          empty;

    always #5 clk = ~clk;

    rob_mc #(.DEPTH(DEPTH), .N_CDB(N_CDB), .COMMIT_W(COMMIT_W)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_entry(issue_entry),
        .issue_ready(issue_ready), .issue_idx(issue_idx), .cdb(cdb), .cdb_en(cdb_en),
        .commit_hold(commit_hold), .flush(flush), .flush_idx(flush_idx),
        .commit_valid(commit_valid), .commit_entry(commit_entry), .commit_idx(commit_idx),
        .rob_data(rob_data), .count(count), .full(full), .empty(empty)
    );

    // Reference model: occupied entries oldest first; mq[j] lives at index (m_head+j)%DEPTH.
    rob_entry_t          mq[$];
    int                  m_head;
    logic [COMMIT_W-1:0] e_valid;
    rob_entry_t          e_entry[COMMIT_W];
    int                  e_idx[COMMIT_W];
    int                  n_cmp = 0;
    int                  n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rob_entry_t mk_entry(input bit store);
        rob_entry_t e;
        e.inst      = $urandom;
        e.inst[6:0] = store ? op_store : OP_ALU;
        e.rd_addr   = 5'($urandom);
        e.rd_data   = $urandom;
        e.rs1_data  = $urandom;
        e.rs2_data  = $urandom;
        e.mem_addr  = $urandom;
        e.mem_rmask = 4'($urandom);
        e.mem_wmask = 4'($urandom);
        e.mem_rdata = $urandom;
        e.mem_wdata = $urandom;
        e.ready     = 1'($urandom);
        return e;
    endfunction

    task automatic set_cdb(input int p, input int tag);
        cdb[p].rob_entry = 6'(tag);
        cdb[p].rd_data   = $urandom;
        cdb[p].rs1_data  = $urandom;
        cdb[p].rs2_data  = $urandom;
        cdb[p].mem_addr  = $urandom;
        cdb[p].mem_rmask = 4'($urandom);
        cdb[p].mem_wmask = 4'($urandom);
        cdb[p].mem_rdata = $urandom;
        cdb[p].mem_wdata = $urandom;
        cdb_en[p]        = 1'b1;
    endtask

    // Apply any enabled CDB write whose target is among the first 'limit' entries.
    task automatic model_cdb(input int limit);
        int tag, j;
        for (int p = 0; p < N_CDB; p++) begin
            if (cdb_en[p]) begin
                tag = int'(cdb[p].rob_entry);
                if (tag < DEPTH) begin
                    j = (tag - m_head + DEPTH) % DEPTH;
                    if (j < limit) begin
                        mq[j].rd_data   = cdb[p].rd_data;
                        mq[j].rs1_data  = cdb[p].rs1_data;
                        mq[j].rs2_data  = cdb[p].rs2_data;
                        mq[j].mem_addr  = cdb[p].mem_addr;
                        mq[j].mem_rmask = cdb[p].mem_rmask;
                        mq[j].mem_wmask = cdb[p].mem_wmask;
                        mq[j].mem_rdata = cdb[p].mem_rdata;
                        mq[j].mem_wdata = cdb[p].mem_wdata;
                        mq[j].ready     = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        int sz, keep, n;
        bit stop;
        rob_entry_t e;
        sz      = mq.size();
        e_valid = '0;
        if (flush) begin
            keep = (int'(flush_idx) - m_head + DEPTH) % DEPTH + 1;
            model_cdb(keep);
            while (mq.size() > keep) void'(mq.pop_back());
        end else begin
            n    = 0;
            stop = commit_hold;
            for (int k = 0; k < COMMIT_W; k++) begin
                if (stop || k >= sz || !mq[k].ready || (k > 0 && mq[k].inst[6:0] == op_store)) begin
                    stop = 1'b1;
                end else begin
                    e_valid[k] = 1'b1;
                    e_entry[k] = mq[k];
                    e_idx[k]   = (m_head + k) % DEPTH;
                    n++;
                    if (mq[k].inst[6:0] == op_store) stop = 1'b1;
                end
            end
            model_cdb(sz);
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            m_head = (m_head + n) % DEPTH;
            if (issue && sz < DEPTH) begin
                e       = issue_entry;
                e.ready = 1'b0;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        chk("commit_valid", commit_valid, e_valid);
        for (int k = 0; k < COMMIT_W; k++) begin
            if (e_valid[k]) begin
                chk("commit_idx", commit_idx[k], e_idx[k]);
                chk("commit_entry", commit_entry[k], e_entry[k]);
            end
        end
        chk("count", count, mq.size());
        chk("issue_idx", issue_idx, (m_head + mq.size()) % DEPTH);
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("issue_ready", issue_ready, mq.size() != DEPTH);
        for (int j = 0; j < mq.size(); j++)
            chk("rob_data", rob_data[(m_head + j) % DEPTH], mq[j]);
    endtask

    task automatic clear_inputs();
        issue       = 1'b0;
        cdb_en      = '0;
        commit_hold = 1'b0;
        flush       = 1'b0;
    endtask

    // One clock: predict, advance, compare, then drop the one-shot inputs.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        mq.delete();
        m_head  = 0;
        e_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic issue_one(input bit store);
        issue       = 1'b1;
        issue_entry = mk_entry(store);
        step();
    endtask

    // Make not-ready entries ready, oldest first, until the model is empty.
    task automatic drain();
        int guard, p;
        guard = 0;
        while (mq.size() > 0 && guard < 200) begin
            p = 0;
            for (int j = 0; j < mq.size() && p < N_CDB; j++) begin
                if (!mq[j].ready) begin
                    set_cdb(p, (m_head + j) % DEPTH);
                    p++;
                end
            end
            step();
            guard++;
        end
        chk("drain_empty", empty, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rob_entry_t orig6;
        int tag, p, j, pick;
        bit taken[DEPTH];
        issue_entry = '0;
        cdb         = '0;
        flush_idx   = '0;
        do_reset();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_issue_idx", issue_idx, 0);
        chk("rst_commit_valid", commit_valid, 0);

        // Fill to 16, 17th dropped
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_idx", issue_idx, i);
            issue_one(1'b0);
        end
        chk("full_after16", full, 1'b1);
        chk("ready_after16", issue_ready, 1'b0);
        issue_one(1'b0);
        chk("count_17th", count, DEPTH);
        drain();

        // Two-wide commit of two ALU ops
        do_reset();
        repeat (3) issue_one(1'b0);
        set_cdb(0, 0);
        set_cdb(1, 1);
        step();
        step();
        chk("pair_valid", commit_valid, 2'b11);
        chk("pair_idx0", commit_idx[0], 0);
        chk("pair_idx1", commit_idx[1], 1);
        chk("pair_count", count, 1);

        // Store retires alone
        do_reset();
        issue_one(1'b1);
        issue_one(1'b0);
        set_cdb(0, 0);
        set_cdb(1, 1);
        step();
        step();
        chk("store_valid_a", commit_valid, 2'b01);
        chk("store_idx_a", commit_idx[0], 0);
        step();
        chk("store_valid_b", commit_valid, 2'b01);
        chk("store_idx_b", commit_idx[0], 1);

        // Partial flush
        do_reset();
        repeat (8) issue_one(1'b0);
        orig6     = mq[6];
        flush     = 1'b1;
        flush_idx = 4'd3;
        set_cdb(0, 6);
        set_cdb(1, 2);
        step();
        chk("flush_count", count, 4);
        chk("flush_issue_idx", issue_idx, 4);
        chk("flush_cdb_ignored", rob_data[6], orig6);
        chk("flush_cdb_kept", rob_data[2].ready, 1'b1);
        issue_one(1'b0);
        chk("reissue_ready", rob_data[4].ready, 1'b0);
        flush     = 1'b1;
        flush_idx = 4'd4;
        step();
        chk("flush_noop_count", count, 5);

        // Wrap-around commit group
        do_reset();
        repeat (14) issue_one(1'b0);
        drain();
        repeat (4) issue_one(1'b0);
        set_cdb(0, 14);
        set_cdb(1, 15);
        step();
        set_cdb(0, 0);
        set_cdb(1, 1);
        step();
        chk("wrap_idx0", commit_idx[0], 14);
        chk("wrap_idx1", commit_idx[1], 15);
        step();
        chk("wrap_idx2", commit_idx[0], 0);
        chk("wrap_idx3", commit_idx[1], 1);
        chk("wrap_empty", empty, 1'b1);
        chk("wrap_head", issue_idx, 2);

        // Commit hold, then async reset mid-stream
        do_reset();
        issue_one(1'b0);
        set_cdb(0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            commit_hold = 1'b1;
            issue       = 1'b1;
            issue_entry = mk_entry(1'b0);
            step();
            chk("hold_valid", commit_valid, 0);
        end
        step();
        chk("release_valid", commit_valid, 2'b01);
        rst = 1'b1;
        #2;
        chk("arst_count", count, 0);
        chk("arst_valid", commit_valid, 0);
        chk("arst_empty", empty, 1'b1);
        chk("arst_issue_idx", issue_idx, 0);
        do_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            issue       = ($urandom_range(0, 99) < 60);
            issue_entry = mk_entry($urandom_range(0, 3) == 0);
            commit_hold = ($urandom_range(0, 9) == 0);
            if (mq.size() > 0 && $urandom_range(0, 24) == 0) begin
                flush     = 1'b1;
                flush_idx = IDXW'((m_head + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) taken[i] = 1'b0;
            for (p = 0; p < N_CDB; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 4) != 0 && mq.size() > 0) begin
                        j = $urandom_range(0, mq.size() - 1);
                        pick = (m_head + j) % DEPTH;
                        if (!mq[j].ready && !taken[pick]) begin
                            taken[pick] = 1'b1;
                            set_cdb(p, pick);
                        end
                    end else begin
                        tag = $urandom_range(0, 63);
                        j   = (tag - m_head + DEPTH) % DEPTH;
                        if (tag >= DEPTH || j >= mq.size()) set_cdb(p, tag);
                    end
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
